// File: rtl/rv_xocc_cmd_queue_if.sv
// Signal bundle between the XOCC command queue, the RISC-V core port and the DSA wrapper.
// The queue takes the slave modport; whatever drives the core and DSA sides takes the master modport.
interface rv_xocc_cmd_queue_if #(
    parameter int CMD_DEPTH = 8,
    parameter int RSP_DEPTH = 8
);
    // Core command side
    logic                         cpu_cmd_wr_en;
    logic [31:0]                  cpu_cmd_wdata;
    logic                         cpu_cmd_abort;
    logic                         cpu_cmd_ready;

    // Core response side
    logic                         cpu_rsp_rd_en;
    logic [31:0]                  cpu_rsp_rdata;
    logic                         cpu_rsp_valid;

    // DSA side
    logic [95:0]                  rv_xocc_cmd_buffer;
    logic                         rv_xocc_cmd_empty;
    logic                         rv_xocc_cmd_rd_en;
    logic [31:0]                  rv_xocc_rsp_buffer;
    logic                         rv_xocc_rsp_wr_en;
    logic                         rv_xocc_rsp_full;

    // Status
    logic [$clog2(CMD_DEPTH):0]   cmd_count;
    logic [$clog2(RSP_DEPTH):0]   rsp_count;
    logic [3:0]                   err_flags;
    logic                         err_clear;

    modport slave (
        input  cpu_cmd_wr_en, cpu_cmd_wdata, cpu_cmd_abort, cpu_rsp_rd_en,
               rv_xocc_cmd_rd_en, rv_xocc_rsp_buffer, rv_xocc_rsp_wr_en, err_clear,
        output cpu_cmd_ready, cpu_rsp_rdata, cpu_rsp_valid,
               rv_xocc_cmd_buffer, rv_xocc_cmd_empty, rv_xocc_rsp_full,
               cmd_count, rsp_count, err_flags
    );

    modport master (
        output cpu_cmd_wr_en, cpu_cmd_wdata, cpu_cmd_abort, cpu_rsp_rd_en,
               rv_xocc_cmd_rd_en, rv_xocc_rsp_buffer, rv_xocc_rsp_wr_en, err_clear,
        input  cpu_cmd_ready, cpu_rsp_rdata, cpu_rsp_valid,
               rv_xocc_cmd_buffer, rv_xocc_cmd_empty, rv_xocc_rsp_full,
               cmd_count, rsp_count, err_flags
    );
endinterface

// File: rtl/rv_xocc_cmd_queue.sv
// XOCC command/response queue: packs three 32-bit core words into a 96-bit DSA command,
// buffers DSA responses for the core, and keeps occupancy counts and sticky protocol errors.
module rv_xocc_cmd_queue #(
    parameter int CMD_DEPTH = 8,
    parameter int RSP_DEPTH = 8
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    rv_xocc_cmd_queue_if.slave    bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2
    } asm_state_t;

    asm_state_t        state, state_next;
    logic [63:0]       hold, hold_next;
    logic              cmd_ready;
    logic              cmd_push;
    logic              cmd_ovf;

    logic [95:0]       cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]    cmd_wr_ptr, cmd_rd_ptr;
    logic [CAW:0]      cmd_cnt;
    logic              cmd_full, cmd_empty, cmd_pop;

    logic [31:0]       rsp_mem [RSP_DEPTH];
    logic [RAW-1:0]    rsp_wr_ptr, rsp_rd_ptr;
    logic [RAW:0]      rsp_cnt;
    logic              rsp_full, rsp_empty, rsp_push, rsp_pop;

    logic [3:0]        err_set, err_q;

    // Ready only drops when the word would complete a command that has nowhere to go.
    assign cmd_ready = !(state == W2 && cmd_full);

    // ------------------------------------------------------------------
    // Assembler FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        hold_next  = hold;
        cmd_push   = 1'b0;
        cmd_ovf    = 1'b0;

        if (bus.cpu_cmd_abort) begin
            state_next = W0;
            hold_next  = '0;
        end else if (bus.cpu_cmd_wr_en) begin
            if (!cmd_ready) begin
                cmd_ovf = 1'b1;
            end else begin
                case (state)
                    W0: begin
                        hold_next[31:0] = bus.cpu_cmd_wdata;
                        state_next      = W1;
                    end
                    W1: begin
                        hold_next[63:32] = bus.cpu_cmd_wdata;
                        state_next       = W2;
                    end
                    W2: begin
                        cmd_push   = 1'b1;
                        state_next = W0;
                    end
                    default: state_next = W0;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state <= W0;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign cmd_full  = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_pop   = bus.rv_xocc_cmd_rd_en && !cmd_empty;

    // NOTE: storage arrays are not reset; emptiness comes from the reset count and the head is gated to zero.
    always_ff @(posedge axi_aclk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= {bus.cpu_cmd_wdata, hold};
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + (CAW+1)'(1);
                2'b01:   cmd_cnt <= cmd_cnt - (CAW+1)'(1);
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign rsp_full  = (rsp_cnt == (RAW+1)'(RSP_DEPTH));
    assign rsp_empty = (rsp_cnt == '0);
    assign rsp_push  = bus.rv_xocc_rsp_wr_en && !rsp_full;
    assign rsp_pop   = bus.cpu_rsp_rd_en && !rsp_empty;

    always_ff @(posedge axi_aclk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr] <= bus.rv_xocc_rsp_buffer;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_cnt    <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + (RAW+1)'(1);
                2'b01:   rsp_cnt <= rsp_cnt - (RAW+1)'(1);
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors: a new event beats a simultaneous clear for its own bit.
    // ------------------------------------------------------------------
    assign err_set = {
        bus.cpu_rsp_rd_en     && rsp_empty,
        bus.rv_xocc_rsp_wr_en && rsp_full,
        bus.rv_xocc_cmd_rd_en && cmd_empty,
        cmd_ovf
    };

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            err_q <= '0;
        end else begin
            err_q <= (bus.err_clear ? 4'b0000 : err_q) | err_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cpu_cmd_ready      = cmd_ready;
    assign bus.rv_xocc_cmd_empty  = cmd_empty;
    assign bus.rv_xocc_cmd_buffer = cmd_empty ? 96'h0 : cmd_mem[cmd_rd_ptr];
    assign bus.rv_xocc_rsp_full   = rsp_full;
    assign bus.cpu_rsp_valid      = !rsp_empty;
    assign bus.cpu_rsp_rdata      = rsp_empty ? 32'h0 : rsp_mem[rsp_rd_ptr];
    assign bus.cmd_count          = cmd_cnt;
    assign bus.rsp_count          = rsp_cnt;
    assign bus.err_flags          = err_q;

endmodule
